// File: rtl/dma_pkg.sv
// Shared types for the 8237A-style DMA request agent: FSM state encoding,
// transfer-direction constants and the FIFO readiness rule.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    ACK     = 3'd2,
    HOLDOFF = 3'd3,
    TERM    = 3'd4
  } dma_agent_state_t;

  localparam logic DIR_IO2MEM = 1'b0;
  localparam logic DIR_MEM2IO = 1'b1;

  // I/O->memory needs data to send; memory->I/O needs room to receive.
  function automatic logic agent_ready(input logic dir, input logic full, input logic empty);
    return (dir == DIR_MEM2IO) ? !full : !empty;
  endfunction

endpackage

// File: rtl/dma_req_agent_if.sv
// DMA channel pin bundle between an 8237A-style controller (master) and a
// peripheral request agent (slave).
interface dma_req_agent_if #(
  parameter int DATA_W = 8
);
  logic              DREQ;
  logic              DACK;
  logic              IOR_N;
  logic              IOW_N;
  logic              EOP_N;
  logic [DATA_W-1:0] DB_IN;
  logic [DATA_W-1:0] DB_OUT;
  logic              DB_OE;

  modport master (
    input  DREQ, DB_OUT, DB_OE,
    output DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

  modport slave (
    output DREQ, DB_OUT, DB_OE,
    input  DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );
endinterface

// File: rtl/dma_sync_fifo.sv
// Show-ahead synchronous FIFO; rejects pops when empty and pushes when full,
// reporting each rejected request for the caller's sticky error flags.
module dma_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count_next,
  output logic                         push_drop,
  output logic                         pop_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign pop_ok    = pop & ~empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop_ok);
  assign push_drop = push & ~push_ok;
  assign pop_drop  = pop & empty;
  assign head      = empty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

endmodule

// File: rtl/dma_req_agent.sv
// Peripheral endpoint of a DREQ/DACK DMA channel: requests service, moves
// FIFO data on IOR_N/IOW_N strobes and terminates on EOP_N.
module dma_req_agent
  import dma_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               DIR,
  input  logic               DEMAND,
  input  logic               DREQ_ACTIVE_LOW,
  input  logic               DACK_ACTIVE_LOW,
  dma_req_agent_if.slave     bus,
  input  logic               LOC_WR_EN,
  input  logic [DATA_W-1:0]  LOC_WR_DATA,
  input  logic               LOC_RD_EN,
  output logic [DATA_W-1:0]  LOC_RD_DATA,
  output logic               FULL,
  output logic               EMPTY,
  output logic               DONE,
  output logic               OVERRUN,
  output logic               UNDERRUN
);
  localparam int CW = $clog2(DEPTH+1);

  dma_agent_state_t state_reg, state_next;
  logic             dreq_reg, dreq_next;
  logic             ior_q_reg, ior_qq_reg, iow_q_reg, iow_qq_reg, eop_q_reg;
  logic             done_reg, overrun_reg, underrun_reg;
  logic             dack_act, in_ack, strb_ior, strb_iow, bus_xfer;
  logic             fifo_push, fifo_pop, push_drop, pop_drop;
  logic             ready, ready_post;
  logic [DATA_W-1:0] push_data, head;
  logic [CW-1:0]    count_next;

  assign dack_act = bus.DACK ^ DACK_ACTIVE_LOW;
  assign in_ack   = (state_reg == ACK);

  // Falling edge of the registered strobe, so each pin pulse yields one transfer.
  assign strb_ior = ior_qq_reg & ~ior_q_reg & dack_act;
  assign strb_iow = iow_qq_reg & ~iow_q_reg & dack_act;
  assign bus_xfer = in_ack & ((DIR == DIR_MEM2IO) ? strb_iow : strb_ior);

  assign fifo_push = (DIR == DIR_MEM2IO) ? bus_xfer  : LOC_WR_EN;
  assign fifo_pop  = (DIR == DIR_MEM2IO) ? LOC_RD_EN : bus_xfer;
  assign push_data = (DIR == DIR_MEM2IO) ? bus.DB_IN : LOC_WR_DATA;

  dma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .srst       (RESET),
    .push       (fifo_push),
    .push_data  (push_data),
    .pop        (fifo_pop),
    .head       (head),
    .full       (FULL),
    .empty      (EMPTY),
    .count_next (count_next),
    .push_drop  (push_drop),
    .pop_drop   (pop_drop)
  );

  assign ready      = agent_ready(DIR, FULL, EMPTY);
  assign ready_post = (DIR == DIR_MEM2IO) ? (count_next != CW'(DEPTH)) : (count_next != '0);

  always_comb begin
    state_next = state_reg;
    dreq_next  = dreq_reg;
    case (state_reg)
      IDLE: begin
        dreq_next = 1'b0;
        if (ENABLE && ready) begin
          state_next = REQ;
          dreq_next  = 1'b1;
        end
      end
      REQ: begin
        if (!eop_q_reg) begin
          state_next = TERM;
          dreq_next  = 1'b0;
        end else if (dack_act) begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (DEMAND) begin
          dreq_next = ready_post;
        end else if (bus_xfer) begin
          dreq_next = 1'b0;
        end
        if (!eop_q_reg) begin
          state_next = TERM;
          dreq_next  = 1'b0;
        end else if (!dack_act) begin
          if (DEMAND) begin
            state_next = ready_post ? REQ : IDLE;
            dreq_next  = ready_post;
          end else begin
            state_next = HOLDOFF;
            dreq_next  = 1'b0;
          end
        end
      end
      HOLDOFF: begin
        state_next = IDLE;
        dreq_next  = 1'b0;
      end
      TERM: begin
        dreq_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
        dreq_next  = 1'b0;
      end
    endcase
    if (!ENABLE) begin
      state_next = IDLE;
      dreq_next  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      dreq_reg   <= 1'b0;
      ior_q_reg  <= 1'b1;
      ior_qq_reg <= 1'b1;
      iow_q_reg  <= 1'b1;
      iow_qq_reg <= 1'b1;
      eop_q_reg  <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dreq_reg   <= dreq_next;
      ior_q_reg  <= bus.IOR_N;
      ior_qq_reg <= ior_q_reg;
      iow_q_reg  <= bus.IOW_N;
      iow_qq_reg <= iow_q_reg;
      eop_q_reg  <= bus.EOP_N;
      done_reg   <= (state_next == TERM) && (state_reg != TERM);
    end
  end

  // Error flags persist until the channel is disarmed.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (push_drop) begin
        overrun_reg <= 1'b1;
      end
      if (pop_drop) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  assign bus.DREQ   = dreq_reg ^ DREQ_ACTIVE_LOW;
  assign bus.DB_OE  = in_ack & (DIR == DIR_IO2MEM) & dack_act & ~bus.IOR_N;
  assign bus.DB_OUT = (in_ack && (DIR == DIR_IO2MEM)) ? head : '0;

  assign LOC_RD_DATA = head;
  assign DONE        = done_reg;
  assign OVERRUN     = overrun_reg;
  assign UNDERRUN    = underrun_reg;

endmodule
